emblem_sprite_engine: RTL and testbench

//  Parametrised, pipelined successor to the fixed emblem overlay. Draws N_SPR bitmap sprites
//  (per-sprite position, colour, enable, blink) at integer scale over the VGA raster. Sits between
//  the sync generator and the final colour mux. Sprite config is written at any time into shadow

---
 rtl/emblem_sprite_engine_pkg.sv | 33 +++
 rtl/emblem_sprite_engine_if.sv | 35 +++
 rtl/emblem_sprite_engine_rom.sv | 34 +++
 rtl/emblem_sprite_engine.sv | 205 ++++++++++++++++++++
 tb/tb_emblem_sprite_engine.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/emblem_sprite_engine_pkg.sv
// Shared types and constants for the emblem sprite engine: RGB222 colours,
// the per-sprite configuration record, the commit FSM encoding and a span helper.
package emblem_pkg;

    localparam logic [5:0] BLACK = 6'b00_00_00;
    localparam logic [5:0] GOLD  = 6'b11_10_00;
    localparam logic [5:0] RED   = 6'b11_00_00;
    localparam logic [5:0] WHITE = 6'b11_11_11;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [5:0] color;
        logic       en;
        logic       blink;
    } spr_cfg_t;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        COMMIT = 1'b1
    } commit_state_t;

    // True when pos lies in [origin, origin+len). Done in 11 bits so a sprite
    // near column/row 1023 is clipped instead of wrapping back to 0.
    function automatic logic in_span(input logic [9:0]  pos,
                                     input logic [9:0]  origin,
                                     input logic [10:0] len);
        logic [10:0] span_end;
        span_end = {1'b0, origin} + len;
        return ({1'b0, pos} >= {1'b0, origin}) && ({1'b0, pos} < span_end);
    endfunction

endpackage

// File: rtl/emblem_sprite_engine_if.sv
// Raster, configuration handshake and overlay output bundle of the sprite engine.
// The master drives raster and config; the slave (the engine) answers with
// cfg_ready and the overlay pixel.
interface emblem_sprite_engine_if;

    logic [9:0] x;
    logic [9:0] y;
    logic       active;
    logic       frame_start;

    logic       cfg_valid;
    logic       cfg_ready;
    logic [1:0] cfg_sel;
    logic [9:0] cfg_x;
    logic [9:0] cfg_y;
    logic [5:0] cfg_color;
    logic       cfg_en;
    logic       cfg_blink;

    logic       draw;
    logic [5:0] rgb;

    modport master (
        output x, y, active, frame_start,
        output cfg_valid, cfg_sel, cfg_x, cfg_y, cfg_color, cfg_en, cfg_blink,
        input  cfg_ready, draw, rgb
    );

    modport slave (
        input  x, y, active, frame_start,
        input  cfg_valid, cfg_sel, cfg_x, cfg_y, cfg_color, cfg_en, cfg_blink,
        output cfg_ready, draw, rgb
    );

endinterface

// File: rtl/emblem_sprite_engine_rom.sv
// Combinational sprite bitmap store. Each sprite id has its own pattern; bit [c]
// of the row word is the pixel in column c (LSB = leftmost). Rows outside the
// bitmap height read as all zeros.
module emblem_sprite_rom #(
    parameter int SPR_W = 48,
    parameter int SPR_H = 45
) (
    input  logic [1:0]       i_id,
    input  logic [5:0]       i_row,
    output logic [SPR_W-1:0] o_word
);

    logic [5:0] w_col;

    // Build the row word column by column from the per-id pattern.
    always_comb begin
        o_word = '0;
        w_col  = 6'd0;
        if ({1'b0, i_row} < 7'(SPR_H)) begin
            for (int c = 0; c < SPR_W; c++) begin
                w_col = 6'(c);
                case (i_id)
                    2'd0:    o_word[c] = (i_row[0] == w_col[0]);
                    2'd1:    o_word[c] = ~w_col[1];
                    2'd2:    o_word[c] = w_col[0] | i_row[1];
                    default: o_word[c] = 1'b1;
                endcase
            end
        end else begin
            o_word = '0;
        end
    end

endmodule

// File: rtl/emblem_sprite_engine.sv
// Multi-sprite overlay: shadow/live config banks with a per-frame commit FSM,
// a frame counter for blinking, and a two-stage hit/lookup pipeline.
module emblem_sprite_engine
    import emblem_pkg::*;
#(
    parameter int N_SPR      = 3,
    parameter int SPR_W      = 48,
    parameter int SPR_H      = 45,
    parameter int SCALE_LOG2 = 0,
    parameter int BLINK_BIT  = 5
) (
    input logic                  clk,
    input logic                  rst,
    emblem_sprite_engine_if.slave bus
);

    localparam logic [1:0]  LAST_IDX = 2'(N_SPR - 1);
    localparam logic [10:0] HIT_W    = 11'(SPR_W << SCALE_LOG2);
    localparam logic [10:0] HIT_H    = 11'(SPR_H << SCALE_LOG2);

    // Commit FSM and frame counter
    commit_state_t      r_state;
    commit_state_t      w_state_nxt;
    logic [1:0]         r_idx;
    logic [1:0]         w_idx_nxt;
    logic               w_fcnt_inc;
    logic [BLINK_BIT:0] r_frame_cnt;
    logic               r_cfg_ready;
    logic               w_cfg_hs;
    spr_cfg_t           w_cfg_in;

    // Config banks
    spr_cfg_t r_shadow [N_SPR];
    spr_cfg_t r_live   [N_SPR];

    // Stage 1
    logic [N_SPR-1:0] w_hit;
    logic [5:0]       w_col [N_SPR];
    logic [5:0]       w_row [N_SPR];
    logic [N_SPR-1:0] r_s1_hit;
    logic [5:0]       r_s1_col   [N_SPR];
    logic [5:0]       r_s1_row   [N_SPR];
    logic [5:0]       r_s1_color [N_SPR];
    logic             r_s1_active;

    // Stage 2
    logic [SPR_W-1:0] w_rom_word [N_SPR];
    logic [N_SPR-1:0] w_lit;
    logic             w_draw;
    logic [5:0]       w_rgb;
    logic             r_draw;
    logic [5:0]       r_rgb;

    assign w_cfg_hs = bus.cfg_valid & r_cfg_ready;
    assign w_cfg_in = {bus.cfg_x, bus.cfg_y, bus.cfg_color, bus.cfg_en, bus.cfg_blink};

    assign bus.cfg_ready = r_cfg_ready;
    assign bus.draw      = r_draw;
    assign bus.rgb       = r_rgb;

    // Commit FSM next state: frame_start in IDLE launches one copy per slot.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_fcnt_inc  = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.frame_start) begin
                    w_state_nxt = COMMIT;
                    w_idx_nxt   = 2'd0;
                    w_fcnt_inc  = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                    w_idx_nxt   = 2'd0;
                end
            end
            COMMIT: begin
                if (r_idx == LAST_IDX) begin
                    w_state_nxt = IDLE;
                    w_idx_nxt   = 2'd0;
                end else begin
                    w_state_nxt = COMMIT;
                    w_idx_nxt   = r_idx + 2'd1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_idx_nxt   = 2'd0;
            end
        endcase
    end

    // FSM state, copy index, ready flag and frame counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_idx       <= 2'd0;
            r_cfg_ready <= 1'b1;
            r_frame_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_cfg_ready <= (w_state_nxt == IDLE);
            if (w_fcnt_inc) begin
                r_frame_cnt <= r_frame_cnt + (BLINK_BIT + 1)'(1);
            end else begin
                r_frame_cnt <= r_frame_cnt;
            end
        end
    end

    // Shadow bank takes handshakes (out-of-range slots drop); live bank is
    // loaded one slot per COMMIT cycle so the raster never sees a torn update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < N_SPR; s++) begin
                r_shadow[s] <= '0;
                r_live[s]   <= '0;
            end
        end else begin
            for (int s = 0; s < N_SPR; s++) begin
                if (w_cfg_hs && (bus.cfg_sel == 2'(s))) begin
                    r_shadow[s] <= w_cfg_in;
                end else begin
                    r_shadow[s] <= r_shadow[s];
                end
                if ((r_state == COMMIT) && (r_idx == 2'(s))) begin
                    r_live[s] <= r_shadow[s];
                end else begin
                    r_live[s] <= r_live[s];
                end
            end
        end
    end

    // Per-slot visibility, clipped hit window and scaled bitmap offsets.
    always_comb begin
        for (int s = 0; s < N_SPR; s++) begin
            w_col[s] = 6'(({1'b0, bus.x} - {1'b0, r_live[s].x}) >> SCALE_LOG2);
            w_row[s] = 6'(({1'b0, bus.y} - {1'b0, r_live[s].y}) >> SCALE_LOG2);
            w_hit[s] = r_live[s].en
                     & ~(r_live[s].blink & r_frame_cnt[BLINK_BIT])
                     & in_span(bus.x, r_live[s].x, HIT_W)
                     & in_span(bus.y, r_live[s].y, HIT_H);
        end
    end

    // Stage 1 registers: hit, offsets, colour snapshot and active flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_hit    <= '0;
            r_s1_active <= 1'b0;
            for (int s = 0; s < N_SPR; s++) begin
                r_s1_col[s]   <= 6'd0;
                r_s1_row[s]   <= 6'd0;
                r_s1_color[s] <= BLACK;
            end
        end else begin
            r_s1_hit    <= w_hit;
            r_s1_active <= bus.active;
            for (int s = 0; s < N_SPR; s++) begin
                r_s1_col[s]   <= w_col[s];
                r_s1_row[s]   <= w_row[s];
                r_s1_color[s] <= r_live[s].color;
            end
        end
    end

    for (genvar g = 0; g < N_SPR; g++) begin : g_rom
        emblem_sprite_rom #(
            .SPR_W (SPR_W),
            .SPR_H (SPR_H)
        ) u_rom (
            .i_id   (2'(g)),
            .i_row  (r_s1_row[g]),
            .o_word (w_rom_word[g])
        );
    end

    // Stage 2 lookup: lowest-index slot with a set bitmap bit wins.
    always_comb begin
        w_lit  = '0;
        w_draw = 1'b0;
        w_rgb  = BLACK;
        for (int s = 0; s < N_SPR; s++) begin
            w_lit[s] = r_s1_active & r_s1_hit[s] & w_rom_word[s][r_s1_col[s]];
        end
        for (int s = 0; s < N_SPR; s++) begin
            w_rgb  = (w_lit[s] && !w_draw) ? r_s1_color[s] : w_rgb;
            w_draw = w_draw | w_lit[s];
        end
    end

    // Stage 2 registers: the overlay outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_draw <= 1'b0;
            r_rgb  <= BLACK;
        end else begin
            r_draw <= w_draw;
            r_rgb  <= w_rgb;
        end
    end

endmodule

// File: tb/tb_emblem_sprite_engine.sv
// Scoreboard bench for emblem_sprite_engine: a driver issues raster pixels and
// config traffic while an arithmetic reference model pushes the expected pixel
// into a queue; a negedge monitor pops and compares the DUT overlay output.
module tb_emblem_sprite_engine;

    localparam int N_SPR      = 3;
    localparam int SPR_W      = 48;
    localparam int SPR_H      = 45;
    localparam int SCALE_LOG2 = 1;
    localparam int BLINK_BIT  = 0;
    localparam int SCALE      = 1 << SCALE_LOG2;

    localparam int C_RED   = 48;   // 6'b110000
    localparam int C_WHITE = 63;   // 6'b111111
    localparam int C_GOLD  = 56;   // 6'b111000

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;

    emblem_sprite_engine_if bus();

    emblem_sprite_engine #(
        .N_SPR      (N_SPR),
        .SPR_W      (SPR_W),
        .SPR_H      (SPR_H),
        .SCALE_LOG2 (SCALE_LOG2),
        .BLINK_BIT  (BLINK_BIT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state
    int sh_x [N_SPR], sh_y [N_SPR], sh_c [N_SPR];
    bit sh_en[N_SPR], sh_bl[N_SPR];
    int lv_x [N_SPR], lv_y [N_SPR], lv_c [N_SPR];
    bit lv_en[N_SPR], lv_bl[N_SPR];
    int m_fcnt = 0;
    int m_left = 0;   // commit cycles still to run

    typedef struct { int due; bit d; int c; int x; int y; } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
        end
    endtask

    // Bitmap contents described as arithmetic patterns per sprite id.
    function automatic bit bmp(input int id, input int row, input int col);
        if (row < 0 || row >= SPR_H || col < 0 || col >= SPR_W) return 1'b0;
        case (id)
            0:       return (row % 2) == (col % 2);
            1:       return ((col / 2) % 2) == 0;
            2:       return (col % 2 == 1) || ((row / 2) % 2 == 1);
            default: return 1'b1;
        endcase
    endfunction

    function automatic void model_pix(input int x, input int y, input bit act,
                                      output bit d, output int c);
        bit vis;
        d = 1'b0;
        c = 0;
        if (act) begin
            for (int s = 0; s < N_SPR; s++) begin
                vis = lv_en[s] && !(lv_bl[s] && (((m_fcnt >> BLINK_BIT) & 1) == 1));
                if (!d && vis &&
                    x >= lv_x[s] && x < lv_x[s] + SPR_W * SCALE &&
                    y >= lv_y[s] && y < lv_y[s] + SPR_H * SCALE &&
                    bmp(s, (y - lv_y[s]) / SCALE, (x - lv_x[s]) / SCALE)) begin
                    d = 1'b1;
                    c = lv_c[s];
                end
            end
        end
    endfunction

    function automatic void model_clear();
        for (int s = 0; s < N_SPR; s++) begin
            sh_x[s] = 0; sh_y[s] = 0; sh_c[s] = 0; sh_en[s] = 0; sh_bl[s] = 0;
            lv_x[s] = 0; lv_y[s] = 0; lv_c[s] = 0; lv_en[s] = 0; lv_bl[s] = 0;
        end
        m_fcnt = 0;
        m_left = 0;
    endfunction

    // One clock of stimulus: check ready, queue the expected pixel, advance the model.
    task automatic cycle();
        bit   d;
        int   c;
        exp_t e;
        check("cfg_ready", int'(bus.cfg_ready), (m_left == 0) ? 1 : 0);
        model_pix(int'(bus.x), int'(bus.y), bus.active, d, c);
        e.due = cyc + 2; e.d = d; e.c = c; e.x = int'(bus.x); e.y = int'(bus.y);
        exp_q.push_back(e);
        if (bus.cfg_valid && m_left == 0 && int'(bus.cfg_sel) < N_SPR) begin
            sh_x[bus.cfg_sel]  = int'(bus.cfg_x);
            sh_y[bus.cfg_sel]  = int'(bus.cfg_y);
            sh_c[bus.cfg_sel]  = int'(bus.cfg_color);
            sh_en[bus.cfg_sel] = bus.cfg_en;
            sh_bl[bus.cfg_sel] = bus.cfg_blink;
        end
        if (m_left > 0) begin
            m_left--;
        end else if (bus.frame_start) begin
            m_fcnt++;
            for (int s = 0; s < N_SPR; s++) begin
                lv_x[s] = sh_x[s]; lv_y[s] = sh_y[s]; lv_c[s] = sh_c[s];
                lv_en[s] = sh_en[s]; lv_bl[s] = sh_bl[s];
            end
            m_left = N_SPR;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pix(input int x, input int y, input bit act);
        bus.x      = 10'(x);
        bus.y      = 10'(y);
        bus.active = act && (m_left == 0);
        cycle();
    endtask

    task automatic idle();
        pix(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), 1'b0);
    endtask

    task automatic cfg_set(input int sel, input int x, input int y, input int c,
                           input bit en, input bit bl);
        bus.cfg_sel   = 2'(sel);
        bus.cfg_x     = 10'(x);
        bus.cfg_y     = 10'(y);
        bus.cfg_color = 6'(c);
        bus.cfg_en    = en;
        bus.cfg_blink = bl;
    endtask

    task automatic cfg_write(input int sel, input int x, input int y, input int c,
                             input bit en, input bit bl);
        bit acc;
        acc = 1'b0;
        cfg_set(sel, x, y, c, en, bl);
        bus.cfg_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            acc = (m_left == 0);
            idle();
            if (acc) break;
        end
        if (!acc) check("cfg_accept_timeout", 0, 1);
        bus.cfg_valid = 1'b0;
    endtask

    task automatic frame();
        bus.frame_start = 1'b1;
        idle();
        bus.frame_start = 1'b0;
        repeat (N_SPR) idle();
    endtask

    task automatic scan_rect(input int x0, input int y0, input int w, input int h);
        for (int j = 0; j < h; j++) begin
            for (int i = 0; i < w; i++) begin
                pix((x0 + i) % 1024, (y0 + j) % 1024, 1'b1);
            end
        end
    endtask

    task automatic scan_rand(input int cx, input int cy, input int n);
        for (int i = 0; i < n; i++) begin
            pix((cx + 1024 + int'($urandom_range(0, 220)) - 20) % 1024,
                (cy + 1024 + int'($urandom_range(0, 110)) - 10) % 1024, 1'b1);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        check("rst_draw", int'(bus.draw), 0);
        check("rst_rgb", int'(bus.rgb), 0);
        check("rst_cfg_ready", int'(bus.cfg_ready), 1);
        model_clear();
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: compare the overlay output against the queued expectation.
    always @(negedge clk) begin
        if (!rst && exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            mon_e = exp_q.pop_front();
            check($sformatf("draw(%0d,%0d)", mon_e.x, mon_e.y), int'(bus.draw), int'(mon_e.d));
            check($sformatf("rgb(%0d,%0d)", mon_e.x, mon_e.y), int'(bus.rgb), mon_e.c);
        end
    end

    initial begin
        bus.x = 10'd0; bus.y = 10'd0; bus.active = 1'b0; bus.frame_start = 1'b0;
        bus.cfg_valid = 1'b0;
        cfg_set(0, 0, 0, 0, 1'b0, 1'b0);
        model_clear();

        // 1. reset held mid-frame, then a quiet frame with no configuration
        #2 rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            bus.x = 10'($urandom_range(0, 1023));
            bus.y = 10'($urandom_range(0, 1023));
            bus.active = 1'b1;
            @(negedge clk);
            check("rst_hold_draw", int'(bus.draw), 0);
            check("rst_hold_rgb", int'(bus.rgb), 0);
            check("rst_hold_ready", int'(bus.cfg_ready), 1);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 200; i++) pix(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), 1'b1);

        // 2. single sprite at (100,50); commit holds cfg_ready low for N_SPR cycles
        cfg_write(0, 100, 50, C_RED, 1'b1, 1'b0);
        frame();
        pix(100, 50, 1'b1);
        scan_rect(96, 48, 104, 4);
        scan_rect(96, 138, 104, 3);

        // 3. overlap priority: slot 0 over slot 1
        cfg_write(1, 100, 50, C_WHITE, 1'b1, 1'b0);
        frame();
        scan_rect(98, 50, 40, 6);

        // 4. clipping at the right and bottom edges
        cfg_write(2, 1000, 200, C_GOLD, 1'b1, 1'b0);
        frame();
        scan_rect(990, 200, 34, 4);
        scan_rect(0, 200, 80, 4);
        cfg_write(2, 500, 1000, C_GOLD, 1'b1, 1'b0);
        frame();
        scan_rect(498, 1000, 12, 24);
        scan_rect(498, 0, 12, 6);

        // 5a. handshake coincident with frame_start lands in that commit
        cfg_set(2, 300, 300, C_GOLD, 1'b1, 1'b0);
        bus.cfg_valid = 1'b1;
        bus.frame_start = 1'b1;
        idle();
        bus.cfg_valid = 1'b0;
        bus.frame_start = 1'b0;
        repeat (N_SPR) idle();
        scan_rect(298, 300, 20, 3);

        // 5b. handshake and frame_start during COMMIT: stall, then land; no restart
        bus.frame_start = 1'b1;
        idle();
        cfg_set(1, 600, 100, C_WHITE, 1'b1, 1'b0);
        bus.cfg_valid = 1'b1;
        repeat (N_SPR) idle();
        bus.frame_start = 1'b0;
        idle();
        bus.cfg_valid = 1'b0;
        scan_rect(598, 100, 20, 2);
        scan_rect(98, 50, 12, 2);
        frame();
        scan_rect(598, 100, 20, 3);

        // 6. blinking slot alternates with the frame counter parity
        cfg_write(0, 100, 50, C_RED, 1'b1, 1'b1);
        for (int f = 0; f < 4; f++) begin
            frame();
            scan_rect(100, 50, 8, 2);
        end

        // randomized configurations, including dropped writes to slot 3
        for (int k = 0; k < 6; k++) begin
            int rx, ry;
            rx = (k % 2 == 0) ? int'($urandom_range(940, 1023)) : int'($urandom_range(0, 900));
            ry = int'($urandom_range(0, 1023));
            cfg_write(int'($urandom_range(0, 3)), rx, ry, int'($urandom_range(0, 63)),
                      ($urandom_range(0, 3) != 0), ($urandom_range(0, 1) == 1));
            frame();
            scan_rand(rx, ry, 120);
        end

        // reset during COMMIT aborts the copy and disables every slot
        cfg_write(0, 100, 50, C_RED, 1'b1, 1'b0);
        cfg_write(1, 200, 80, C_WHITE, 1'b1, 1'b0);
        bus.frame_start = 1'b1;
        idle();
        bus.frame_start = 1'b0;
        idle();
        do_reset();
        frame();
        scan_rect(100, 50, 12, 2);
        scan_rect(200, 80, 12, 2);
        for (int i = 0; i < 100; i++) pix(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), 1'b1);

        // drain the scoreboard with a bounded wait
        repeat (3) idle();
        for (int i = 0; i < 10; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        #1;
        check("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
